// File: rtl/tlc_pkg.sv
// Shared traffic-light-controller definitions: phase durations, watchdog
// default, phase-timer state encodings and signal-head light encodings.
package tlc_pkg;

   localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

   localparam int unsigned ONE_SEC     = DEFAULT_CLK_HZ;
   localparam int unsigned THREE_SEC   = 3 * DEFAULT_CLK_HZ;
   localparam int unsigned FIFTEEN_SEC = 15 * DEFAULT_CLK_HZ;
   localparam int unsigned THIRTY_SEC  = 30 * DEFAULT_CLK_HZ;

   // Beyond this many cycles without a clear the light controller is
   // assumed to have lost track of its phase.
   localparam int unsigned WDOG_DEFAULT = 1_600_000_000;

   localparam int unsigned COUNT_W = 31;
   localparam int unsigned SEC_W   = 6;
   localparam logic [SEC_W-1:0] SEC_MAX = 6'd63;

   typedef enum logic [1:0] {
      TS_RUN   = 2'b00,
      TS_HOLD  = 2'b01,
      TS_FAULT = 2'b10
   } timer_state_e;

   typedef enum logic [1:0] {
      LIGHT_RED    = 2'b01,
      LIGHT_YELLOW = 2'b10,
      LIGHT_GREEN  = 2'b11
   } light_e;

   // Cycle count for a whole number of seconds at a given clock rate.
   function automatic logic [COUNT_W-1:0] secs_to_cycles(input int unsigned clk_hz,
                                                         input int unsigned secs);
      return COUNT_W'(clk_hz * secs);
   endfunction

endpackage

// File: rtl/tlc_prescaler.sv
// Sub-second prescaler: counts 0..CLK_HZ-1 alongside the elapsed-cycle
// counter and flags the terminal value so the owner can bump seconds.
module tlc_prescaler
   import tlc_pkg::*;
#(
   parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
   parameter int unsigned PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             clear,
   input  logic             advance,
   output logic [PRE_W-1:0] pre_count,
   output logic             wrap
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;

   // Next prescaler value: clear wins, otherwise step and roll over at CLK_HZ-1.
   always_comb begin
      pre_d = pre_q;
      if (clear) begin
         pre_d = '0;
      end else if (advance) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   // Prescaler register with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   assign pre_count = pre_q;
   assign wrap      = (pre_q == PRE_LAST);

endmodule

// File: rtl/tlc_phase_timer.sv
// Phase timer for the traffic-light controller: counts cycles since the
// last clear, tracks whole seconds, decodes phase-length hits, supports a
// level-sensitive freeze and latches a watchdog fault when no clear arrives.
module tlc_phase_timer
   import tlc_pkg::*;
#(
   parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
   parameter int unsigned WDOG_LIMIT = WDOG_DEFAULT
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               RstCount,
   input  logic               Hold,
   output logic [COUNT_W-1:0] Count,
   output logic [SEC_W-1:0]   SecCount,
   output logic               Tick,
   output logic               Hit1,
   output logic               Hit3,
   output logic               Hit15,
   output logic               Hit30,
   output logic               Fault,
   output logic [1:0]         TimerState
);

   localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   localparam logic [COUNT_W-1:0] WDOG_MAX  = COUNT_W'(WDOG_LIMIT);
   localparam logic [COUNT_W-1:0] WDOG_EDGE = COUNT_W'(WDOG_LIMIT - 1);

   localparam logic [COUNT_W-1:0] HIT1_CNT  = secs_to_cycles(CLK_HZ, 1);
   localparam logic [COUNT_W-1:0] HIT3_CNT  = secs_to_cycles(CLK_HZ, 3);
   localparam logic [COUNT_W-1:0] HIT15_CNT = secs_to_cycles(CLK_HZ, 15);
   localparam logic [COUNT_W-1:0] HIT30_CNT = secs_to_cycles(CLK_HZ, 30);

   timer_state_e       state_q;
   timer_state_e       state_d;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;
   logic [SEC_W-1:0]   sec_q;
   logic [SEC_W-1:0]   sec_d;

   logic               pre_clear;
   logic               pre_advance;
   logic               pre_wrap;
   logic [PRE_W-1:0]   pre_count;
   logic [SEC_W-1:0]   sec_bumped;

   tlc_prescaler #(
      .CLK_HZ (CLK_HZ),
      .PRE_W  (PRE_W)
   ) u_prescaler (
      .Clk       (Clk),
      .Rst       (Rst),
      .clear     (pre_clear),
      .advance   (pre_advance),
      .pre_count (pre_count),
      .wrap      (pre_wrap)
   );

   // Seconds value to use whenever this edge advances the count; saturates.
   always_comb begin
      sec_bumped = sec_q;
      if (pre_wrap && (sec_q != SEC_MAX)) begin
         sec_bumped = sec_q + SEC_W'(1);
      end
   end

   // Next-state and counter update, priority RstCount > watchdog > Hold > increment.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      sec_d       = sec_q;
      pre_clear   = 1'b0;
      pre_advance = 1'b0;
      case (state_q)
         TS_RUN, TS_HOLD: begin
            if (RstCount) begin
               count_d   = '0;
               sec_d     = '0;
               pre_clear = 1'b1;
               state_d   = Hold ? TS_HOLD : TS_RUN;
            end else if (count_q == WDOG_EDGE) begin
               count_d     = WDOG_MAX;
               sec_d       = sec_bumped;
               pre_advance = 1'b1;
               state_d     = TS_FAULT;
            end else if (Hold) begin
               state_d = TS_HOLD;
            end else if (state_q == TS_HOLD) begin
               state_d = TS_RUN;
            end else begin
               count_d     = count_q + COUNT_W'(1);
               sec_d       = sec_bumped;
               pre_advance = 1'b1;
            end
         end
         TS_FAULT: begin
            if (RstCount) begin
               count_d   = '0;
               sec_d     = '0;
               pre_clear = 1'b1;
               state_d   = TS_RUN;
            end
         end
         default: begin
            count_d   = '0;
            sec_d     = '0;
            pre_clear = 1'b1;
            state_d   = TS_RUN;
         end
      endcase
   end

   // State, count and seconds registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= TS_RUN;
         count_q <= '0;
         sec_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sec_q   <= sec_d;
      end
   end

   // Strobe decodes from registered count and prescaler only.
   always_comb begin
      Tick  = (pre_count == '0) && (count_q != '0);
      Hit1  = (count_q == HIT1_CNT);
      Hit3  = (count_q == HIT3_CNT);
      Hit15 = (count_q == HIT15_CNT);
      Hit30 = (count_q == HIT30_CNT);
   end

   assign Count      = count_q;
   assign SecCount   = sec_q;
   assign Fault      = (state_q == TS_FAULT);
   assign TimerState = state_q;

endmodule

// File: tb/tb_tlc_phase_timer.sv
// Directed bench for tlc_phase_timer at CLK_HZ=10, WDOG_LIMIT=400.
module tb_tlc_phase_timer;

   logic        Clk;
   logic        Rst;
   logic        RstCount;
   logic        Hold;
   logic [30:0] Count;
   logic [5:0]  SecCount;
   logic        Tick;
   logic        Hit1;
   logic        Hit3;
   logic        Hit15;
   logic        Hit30;
   logic        Fault;
   logic [1:0]  TimerState;

   int vec_count  = 0;
   int miss_count = 0;

   tlc_phase_timer #(
      .CLK_HZ     (10),
      .WDOG_LIMIT (400)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .RstCount   (RstCount),
      .Hold       (Hold),
      .Count      (Count),
      .SecCount   (SecCount),
      .Tick       (Tick),
      .Hit1       (Hit1),
      .Hit3       (Hit3),
      .Hit15      (Hit15),
      .Hit30      (Hit30),
      .Fault      (Fault),
      .TimerState (TimerState)
   );

   // 10-unit clock period.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed no finish expected finish");
      $fatal(1, "[TB] timeout");
   end

   // Drive one set of inputs across a single rising edge, then settle.
   task automatic applyStimulus(input logic rst, input logic rst_count, input logic hold);
      Rst      = rst;
      RstCount = rst_count;
      Hold     = hold;
      @(posedge Clk);
      #1;
   endtask

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vec_count++;
      assert (observed === expected) else begin
         miss_count++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Check every strobe against expected values.
   task automatic checkStrobes(input string tag, input logic t, input logic h1,
                               input logic h3, input logic h15, input logic h30);
      checkOutput({tag, "_tick"},  32'(Tick),  32'(t));
      checkOutput({tag, "_hit1"},  32'(Hit1),  32'(h1));
      checkOutput({tag, "_hit3"},  32'(Hit3),  32'(h3));
      checkOutput({tag, "_hit15"}, 32'(Hit15), 32'(h15));
      checkOutput({tag, "_hit30"}, 32'(Hit30), 32'(h30));
   endtask

   initial begin
      Rst      = 1'b1;
      RstCount = 1'b0;
      Hold     = 1'b0;

      // Reset with Hold asserted must still land in RUN at zero.
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("rst_count", 32'(Count), 32'd0);
      checkOutput("rst_sec",   32'(SecCount), 32'd0);
      checkOutput("rst_state", 32'(TimerState), 32'd0);
      checkOutput("rst_fault", 32'(Fault), 32'd0);
      checkStrobes("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Free run for 35 cycles.
      for (int i = 1; i <= 35; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput("run_count", 32'(Count), 32'(i));
         checkOutput("run_sec",   32'(SecCount), 32'(i / 10));
         checkOutput("run_tick",  32'(Tick), 32'((i % 10) == 0));
         checkOutput("run_hit1",  32'(Hit1), 32'(i == 10));
         checkOutput("run_hit3",  32'(Hit3), 32'(i == 30));
      end
      checkOutput("run35_state", 32'(TimerState), 32'd0);

      // Clear at 35 (prescaler mid-second), count to 30, clear again.
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("clr35_count", 32'(Count), 32'd0);
      checkOutput("clr35_sec",   32'(SecCount), 32'd0);
      checkOutput("clr35_tick",  32'(Tick), 32'd0);
      for (int i = 1; i <= 30; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput("rerun_tick", 32'(Tick), 32'((i % 10) == 0));
         checkOutput("rerun_hit3", 32'(Hit3), 32'(i == 30));
      end
      checkOutput("at30_count", 32'(Count), 32'd30);
      checkOutput("at30_sec",   32'(SecCount), 32'd3);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("clr30_count", 32'(Count), 32'd0);
      checkOutput("clr30_sec",   32'(SecCount), 32'd0);
      checkOutput("clr30_hit3",  32'(Hit3), 32'd0);
      checkOutput("clr30_tick",  32'(Tick), 32'd0);

      // Freeze at 12 for five cycles, then release.
      for (int i = 1; i <= 12; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pre_hold_count", 32'(Count), 32'd12);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("hold_count", 32'(Count), 32'd12);
         checkOutput("hold_state", 32'(TimerState), 32'd1);
         checkOutput("hold_sec",   32'(SecCount), 32'd1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("release1_count", 32'(Count), 32'd12);
      checkOutput("release1_state", 32'(TimerState), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("release2_count", 32'(Count), 32'd13);

      // Clear and Hold together at 7.
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 7; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("at7_count", 32'(Count), 32'd7);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("clrhold_count", 32'(Count), 32'd0);
      checkOutput("clrhold_state", 32'(TimerState), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("clrhold2_count", 32'(Count), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("clrhold_rel_state", 32'(TimerState), 32'd0);

      // Clear while already frozen at a nonzero count.
      for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("hold5_count", 32'(Count), 32'd5);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("holdclr_count", 32'(Count), 32'd0);
      checkOutput("holdclr_state", 32'(TimerState), 32'd1);

      // Reset in the middle of HOLD.
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("hold4_count", 32'(Count), 32'd4);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("rsthold_count", 32'(Count), 32'd0);
      checkOutput("rsthold_state", 32'(TimerState), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rsthold_next", 32'(Count), 32'd1);

      // Run into the watchdog.
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 400; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (i == 150) checkOutput("wd_hit15", 32'(Hit15), 32'd1);
         if (i == 300) checkOutput("wd_hit30", 32'(Hit30), 32'd1);
         if (i == 399) begin
            checkOutput("wd399_count", 32'(Count), 32'd399);
            checkOutput("wd399_fault", 32'(Fault), 32'd0);
            checkOutput("wd399_state", 32'(TimerState), 32'd0);
         end
      end
      checkOutput("wd_count", 32'(Count), 32'd400);
      checkOutput("wd_fault", 32'(Fault), 32'd1);
      checkOutput("wd_state", 32'(TimerState), 32'd2);
      checkOutput("wd_sec",   32'(SecCount), 32'd40);
      checkOutput("wd_tick",  32'(Tick), 32'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("fault_hold_count", 32'(Count), 32'd400);
         checkOutput("fault_hold_state", 32'(TimerState), 32'd2);
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput("fault_sat_count", 32'(Count), 32'd400);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("fault_clr_count", 32'(Count), 32'd0);
      checkOutput("fault_clr_fault", 32'(Fault), 32'd0);
      checkOutput("fault_clr_state", 32'(TimerState), 32'd0);

      // Back into FAULT, then reset together with a clear request.
      for (int i = 1; i <= 400; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("wd2_fault", 32'(Fault), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("rstfault_count", 32'(Count), 32'd0);
      checkOutput("rstfault_state", 32'(TimerState), 32'd0);
      checkOutput("rstfault_fault", 32'(Fault), 32'd0);
      checkOutput("rstfault_sec",   32'(SecCount), 32'd0);
      checkStrobes("rstfault", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
